// File: rtl/inst_fetch_decode_if.sv
// Instruction issue channel between the fetch/decode unit and the GEMM controller.
// The fetch unit is the master: it presents a decoded instruction with inst_valid
// and holds it until the controller raises inst_ready.
interface inst_fetch_decode_if #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int BUF_ID_WIDTH  = 2,
  parameter int MEM_LOC_WIDTH = 10
);
  logic                     inst_valid;
  logic                     inst_ready;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [BUF_ID_WIDTH-1:0]  buf_id;
  logic [MEM_LOC_WIDTH-1:0] mem_loc;

  modport master (
    output inst_valid,
    output opcode,
    output buf_id,
    output mem_loc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  opcode,
    input  buf_id,
    input  mem_loc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode unit for the GEMM accelerator.
// Holds a writable instruction memory, walks it from a start pulse, skips NOPs,
// stops on HALT / undefined opcode / end of memory, and issues each real
// instruction over a valid/ready channel. Peak rate is one issue per 3 cycles.
module inst_fetch_decode #(
  parameter int OPCODE_WIDTH          = 4,
  parameter int BUF_ID_WIDTH          = 2,
  parameter int MEM_LOC_WIDTH         = 10,
  parameter int INST_WIDTH            = OPCODE_WIDTH + BUF_ID_WIDTH + MEM_LOC_WIDTH,
  parameter int LOG2_INST_MEMORY_SIZE = 10,
  parameter int INST_MEMORY_SIZE      = 1 << LOG2_INST_MEMORY_SIZE,
  parameter logic [OPCODE_WIDTH-1:0] OPC_NOP      = 4'b0000,
  parameter logic [OPCODE_WIDTH-1:0] OPC_LD       = 4'b0010,
  parameter logic [OPCODE_WIDTH-1:0] OPC_ST       = 4'b0011,
  parameter logic [OPCODE_WIDTH-1:0] OPC_GEMM     = 4'b0100,
  parameter logic [OPCODE_WIDTH-1:0] OPC_DRAINSYS = 4'b0101,
  parameter logic [OPCODE_WIDTH-1:0] OPC_HALT     = 4'b1111
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0] start_pc,
  input  logic                             prog_wr_en,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0] prog_wr_addr,
  input  logic [INST_WIDTH-1:0]            prog_wr_data,
  inst_fetch_decode_if.master              bus,
  output logic [LOG2_INST_MEMORY_SIZE-1:0] pc,
  output logic                             busy,
  output logic                             done,
  output logic                             illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [LOG2_INST_MEMORY_SIZE-1:0] LAST_PC =
    LOG2_INST_MEMORY_SIZE'(INST_MEMORY_SIZE - 1);

  logic [INST_WIDTH-1:0]            r_mem [INST_MEMORY_SIZE];
  logic [INST_WIDTH-1:0]            r_rdata;
  logic [2:0]                       r_state;
  logic [LOG2_INST_MEMORY_SIZE-1:0] r_pc;
  logic                             r_valid;
  logic [OPCODE_WIDTH-1:0]          r_opcode;
  logic [BUF_ID_WIDTH-1:0]          r_buf_id;
  logic [MEM_LOC_WIDTH-1:0]         r_mem_loc;
  logic                             r_done;
  logic                             r_illegal;

  logic [OPCODE_WIDTH-1:0]          w_opcode;
  logic [BUF_ID_WIDTH-1:0]          w_buf_id;
  logic [MEM_LOC_WIDTH-1:0]         w_mem_loc;
  logic                             w_stopped;
  logic                             w_last_pc;

  // Fields are packed MSB-first: opcode | buf_id | mem_loc.
  assign w_opcode  = r_rdata[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign w_buf_id  = r_rdata[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
  assign w_mem_loc = r_rdata[MEM_LOC_WIDTH-1:0];
  assign w_stopped = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_last_pc = (r_pc == LAST_PC);

  // Program loading is only allowed while no program is running.
  always_ff @(posedge clk) begin
    if (prog_wr_en && w_stopped) begin
      r_mem[prog_wr_addr] <= prog_wr_data;
    end
  end

  // Synchronous read of the word at pc; consumed in DECODE one cycle after FETCH.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[r_pc];
  end

  // Run-control state machine and issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_buf_id  <= '0;
      r_mem_loc <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pc      <= start_pc;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_opcode)
            OPC_NOP: begin
              // NOPs are skipped; the end of memory stops the run instead of wrapping.
              if (w_last_pc) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_pc    <= r_pc + LOG2_INST_MEMORY_SIZE'(1);
                r_state <= S_FETCH;
              end
            end
            OPC_HALT: begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
            OPC_LD, OPC_ST, OPC_GEMM, OPC_DRAINSYS: begin
              r_opcode  <= w_opcode;
              r_buf_id  <= w_buf_id;
              r_mem_loc <= w_mem_loc;
              r_valid   <= 1'b1;
              r_state   <= S_ISSUE;
            end
            default: begin
              r_illegal <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          endcase
        end
        S_ISSUE: begin
          // Outputs hold until the controller accepts.
          if (r_valid && bus.inst_ready) begin
            r_valid <= 1'b0;
            if (w_last_pc) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + LOG2_INST_MEMORY_SIZE'(1);
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.inst_valid = r_valid;
  assign bus.opcode     = r_opcode;
  assign bus.buf_id     = r_buf_id;
  assign bus.mem_loc    = r_mem_loc;
  assign pc             = r_pc;
  assign busy           = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_ISSUE);
  assign done           = r_done;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Directed bench for inst_fetch_decode: expected issues are queued when a
// program is started and compared against each accepted handshake.
module tb_inst_fetch_decode;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] bid;
    logic [9:0] loc;
    logic [9:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_pc;
  logic        prog_wr_en;
  logic [9:0]  prog_wr_addr;
  logic [15:0] prog_wr_data;
  logic [9:0]  pc;
  logic        busy;
  logic        done;
  logic        illegal;

  int   checks;
  int   errors;
  int   accepts;
  exp_t sb[$];

  inst_fetch_decode_if #(.OPCODE_WIDTH(4), .BUF_ID_WIDTH(2), .MEM_LOC_WIDTH(10)) bus ();

  inst_fetch_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_pc     (start_pc),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .bus          (bus),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] b, input logic [9:0] l);
    return {op, b, l};
  endfunction

  function automatic exp_t ex(input logic [3:0] op, input logic [1:0] b, input logic [9:0] l, input logic [9:0] p);
    exp_t e;
    e.op = op; e.bid = b; e.loc = l; e.pc = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    prog_wr_en = 1'b1; prog_wr_addr = a; prog_wr_data = d;
    tick();
    prog_wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] p);
    start = 1'b1; start_pc = p;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every accepted handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      exp_t e;
      exp_t o;
      accepts++;
      o = ex(bus.opcode, bus.buf_id, bus.mem_loc, pc);
      $display("ISSUE op=%0h buf=%0h loc=%0h pc=%0h", o.op, o.bid, o.loc, o.pc);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL issue observed=%0h expected=%0h", o, e);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; accepts = 0;
    rst_n = 1'b0; start = 1'b0; start_pc = '0;
    prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    bus.inst_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_pc", {22'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_fields", {16'd0, bus.opcode, bus.buf_id, bus.mem_loc}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, illegal}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Program 1: LD, GEMM, ST, HALT with ready high
    load(10'd0, mk(4'h2, 2'd1, 10'h005));
    load(10'd1, mk(4'h4, 2'd0, 10'h000));
    load(10'd2, mk(4'h3, 2'd2, 10'h3FF));
    load(10'd3, mk(4'hF, 2'd0, 10'h000));
    bus.inst_ready = 1'b1;
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd1, 10'h005, 10'd0));
    sb.push_back(ex(4'h4, 2'd0, 10'h000, 10'd1));
    sb.push_back(ex(4'h3, 2'd2, 10'h3FF, 10'd2));
    do_start(10'd0);
    chk("p1_busy", {31'd0, busy}, 32'd1);
    chk("p1_lat_fetch", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("p1_lat_decode", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("p1_lat_issue", {31'd0, bus.inst_valid}, 32'd1);
    wait_done(60);
    chk("p1_pc", {22'd0, pc}, 32'd3);
    chk("p1_illegal", {31'd0, illegal}, 32'd0);
    chk("p1_busy_end", {31'd0, busy}, 32'd0);
    chk("p1_accepts", accepts, 32'd3);
    chk("p1_sb_empty", sb.size(), 32'd0);

    // Program 1 again with backpressure on the first instruction
    bus.inst_ready = 1'b0;
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd1, 10'h005, 10'd0));
    sb.push_back(ex(4'h4, 2'd0, 10'h000, 10'd1));
    sb.push_back(ex(4'h3, 2'd2, 10'h3FF, 10'd2));
    do_start(10'd0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("p2_stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("p2_stall_fields", {16'd0, bus.opcode, bus.buf_id, bus.mem_loc}, {16'd0, mk(4'h2, 2'd1, 10'h005)});
      chk("p2_stall_pc", {22'd0, pc}, 32'd0);
      tick();
    end
    chk("p2_no_accept_in_stall", accepts, 32'd0);
    bus.inst_ready = 1'b1;
    tick();
    chk("p2_one_accept", accepts, 32'd1);
    wait_done(60);
    chk("p2_accepts", accepts, 32'd3);
    chk("p2_sb_empty", sb.size(), 32'd0);

    // Program 3: NOPs skipped, DRAINSYS is the first issue
    load(10'd0, 16'h0000);
    load(10'd1, 16'h0000);
    load(10'd2, 16'h0000);
    load(10'd3, mk(4'h5, 2'd0, 10'h000));
    load(10'd4, mk(4'hF, 2'd0, 10'h000));
    accepts = 0;
    sb.push_back(ex(4'h5, 2'd0, 10'h000, 10'd3));
    do_start(10'd0);
    wait_done(60);
    chk("p3_accepts", accepts, 32'd1);
    chk("p3_pc", {22'd0, pc}, 32'd4);
    chk("p3_sb_empty", sb.size(), 32'd0);

    // Program 4: undefined opcode after LD traps
    load(10'd0, mk(4'h2, 2'd3, 10'h012));
    load(10'd1, mk(4'h8, 2'd0, 10'h000));
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd3, 10'h012, 10'd0));
    do_start(10'd0);
    wait_done(60);
    chk("p4_illegal", {31'd0, illegal}, 32'd1);
    chk("p4_pc", {22'd0, pc}, 32'd1);
    chk("p4_accepts", accepts, 32'd1);
    chk("p4_valid_low", {31'd0, bus.inst_valid}, 32'd0);
    accepts = 0;
    sb.push_back(ex(4'h5, 2'd0, 10'h000, 10'd3));
    do_start(10'd3);
    chk("p4_restart_illegal", {31'd0, illegal}, 32'd0);
    chk("p4_restart_done", {31'd0, done}, 32'd0);
    wait_done(60);
    chk("p4_restart_accepts", accepts, 32'd1);
    chk("p4_restart_illegal_end", {31'd0, illegal}, 32'd0);

    // Program 5: end of memory without HALT, no wrap
    load(10'd1022, mk(4'h2, 2'd1, 10'h01A));
    load(10'd1023, mk(4'h2, 2'd2, 10'h01B));
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd1, 10'h01A, 10'd1022));
    sb.push_back(ex(4'h2, 2'd2, 10'h01B, 10'd1023));
    do_start(10'd1022);
    wait_done(60);
    chk("p5_accepts", accepts, 32'd2);
    chk("p5_pc", {22'd0, pc}, 32'd1023);
    chk("p5_illegal", {31'd0, illegal}, 32'd0);
    chk("p5_sb_empty", sb.size(), 32'd0);

    // Reset while an instruction is presented
    load(10'd0, mk(4'h2, 2'd1, 10'h005));
    load(10'd1, mk(4'h4, 2'd0, 10'h000));
    load(10'd2, mk(4'h3, 2'd2, 10'h3FF));
    load(10'd3, mk(4'hF, 2'd0, 10'h000));
    bus.inst_ready = 1'b0;
    do_start(10'd0);
    tick();
    tick();
    chk("p6_valid_before_rst", {31'd0, bus.inst_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("p6_async_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("p6_async_flags", {29'd0, busy, done, illegal}, 32'd0);
    chk("p6_async_pc", {22'd0, pc}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("p6_idle_after_rst", {30'd0, busy, bus.inst_valid}, 32'd0);

    // Writes while busy are ignored: overwrite attempt of addr 1 with HALT
    bus.inst_ready = 1'b1;
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd1, 10'h005, 10'd0));
    sb.push_back(ex(4'h4, 2'd0, 10'h000, 10'd1));
    sb.push_back(ex(4'h3, 2'd2, 10'h3FF, 10'd2));
    do_start(10'd0);
    load(10'd1, mk(4'hF, 2'd0, 10'h000));
    wait_done(60);
    chk("p7_first_accepts", accepts, 32'd3);
    accepts = 0;
    sb.push_back(ex(4'h2, 2'd1, 10'h005, 10'd0));
    sb.push_back(ex(4'h4, 2'd0, 10'h000, 10'd1));
    sb.push_back(ex(4'h3, 2'd2, 10'h3FF, 10'd2));
    do_start(10'd0);
    wait_done(60);
    chk("p7_rerun_accepts", accepts, 32'd3);
    chk("p7_pc", {22'd0, pc}, 32'd3);
    chk("p7_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_decode.md
Name: inst_fetch_decode

Overview:
- Parametrised instruction fetch/decode unit for the GEMM accelerator.
- Holds a writable instruction memory and sequences it from a start pulse.
- Splits each word into opcode/buf_id/mem_loc and hands it to the controller over a valid/ready handshake.
- Adds run control (start, NOP skip, HALT, illegal-opcode trap, end-of-memory stop, stall under backpressure) beyond a free-running PC.

Parameters:
OPCODE_WIDTH, 4, opcode field width
BUF_ID_WIDTH, 2, buffer-id field width
MEM_LOC_WIDTH, 10, memory-location field width
INST_WIDTH, OPCODE_WIDTH+BUF_ID_WIDTH+MEM_LOC_WIDTH, instruction word width; fields packed MSB-first opcode|buf_id|mem_loc
LOG2_INST_MEMORY_SIZE, 10, PC width
INST_MEMORY_SIZE, 1<<LOG2_INST_MEMORY_SIZE, instruction memory depth
OPC_NOP, 4'b0000, skipped, never issued
OPC_LD, 4'b0010, load
OPC_ST, 4'b0011, store
OPC_GEMM, 4'b0100, gemm
OPC_DRAINSYS, 4'b0101, drain systolic array
OPC_HALT, 4'b1111, stop execution

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins execution at start_pc
start_pc  input  LOG2_INST_MEMORY_SIZE  first PC of program
prog_wr_en  input  1  instruction memory write enable
prog_wr_addr  input  LOG2_INST_MEMORY_SIZE  write address
prog_wr_data  input  INST_WIDTH  write data
inst_valid  output  1  decoded instruction presented
inst_ready  input  1  controller accepts instruction
opcode  output  OPCODE_WIDTH  decoded opcode
buf_id  output  BUF_ID_WIDTH  decoded buffer id
mem_loc  output  MEM_LOC_WIDTH  decoded memory location
pc  output  LOG2_INST_MEMORY_SIZE  address of presented or next instruction
busy  output  1  high in FETCH/DECODE/ISSUE
done  output  1  sticky high after stop until next start
illegal  output  1  sticky; stop was caused by an undefined opcode

Behaviour:
- Reset: state IDLE, pc=0, inst_valid=0, opcode/buf_id/mem_loc=0, busy=0, done=0, illegal=0. Memory contents are not reset. Reset mid-run aborts immediately; nothing further is issued.
- Memory: synchronous read, 1-cycle latency. Writes take effect only in IDLE or DONE; writes are ignored while busy.
- IDLE/DONE + start: pc<=start_pc, done<=0, illegal<=0, go to FETCH. start is ignored while busy.
- FETCH (1 cycle): drive read address pc; go to DECODE.
- DECODE (1 cycle): read data is valid; evaluate the opcode.
  - NOP: pc<=pc+1, go to FETCH.
  - HALT: go to DONE; pc stays at the HALT address.
  - LD/ST/GEMM/DRAINSYS: latch fields into output registers, set inst_valid, go to ISSUE.
  - Any other opcode: illegal<=1, go to DONE; the instruction is not issued.
- ISSUE: outputs hold stable while inst_valid && !inst_ready.
  - On inst_valid && inst_ready: inst_valid<=0 the next cycle.
  - If pc == INST_MEMORY_SIZE-1, go to DONE (no wrap).
  - Otherwise pc<=pc+1 and go to FETCH.
- NOP at the last address: go to DONE, no wrap.
- Issue latency: 2 cycles from start or previous accept to inst_valid, i.e. peak 1 instruction per 3 cycles with ready held high.
- DONE: done=1, busy=0, inst_valid=0. Stays until start or reset.
- A start pulse in the same cycle as a stop transition is ignored.

Test Plan:
- Load LD(buf1,0x005), GEMM(0,0), ST(2,0x3FF), HALT at 0..3; start_pc=0; ready=1 -> three issues with fields {2,1,5},{4,0,0},{3,2,0x3FF}; then done=1, pc=3, illegal=0.
- Same program, ready held low 5 cycles on the first instruction -> inst_valid and fields stable all 5 cycles; exactly one accept; total of three accepts.
- NOP at 0..2, DRAINSYS at 3, HALT at 4 -> the first issue is opcode 5 with pc=3; NOPs are never presented.
- Opcode 4'b1000 at 1 after an LD at 0 -> LD issued, then done=1 and illegal=1 with no second valid. A fresh start clears illegal.
- Program without HALT; start_pc=1022, LD at 1022/1023 -> two issues, then done at pc=1023 with no wrap to 0.
- rst_n low while in ISSUE with valid high -> inst_valid=0 asynchronously, state IDLE. prog_wr_en while busy -> memory unchanged, verified by a rerun.
